// File: rtl/fir_coef_ctrl.sv
`default_nettype none
// ============================================================================
// fir_coef_ctrl
// Stalls the sample stream, drains the FIR, commits shadow coefficients
// atomically and optionally zero-flushes the FIR history.
// Rev 1.0
// ============================================================================
module fir_coef_ctrl #(
    parameter int FIR_LAT = 3,
    parameter int TAPS    = 8,
    parameter int COEF_W  = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [COEF_W-1:0] sw_coeffs,
    input  logic [3:0]        sw_scale,
    input  logic              flush_en,
    input  logic              upd_req,
    output logic              upd_busy,
    output logic [CNT_W-1:0]  upd_count,
    input  logic [7:0]        s_sample,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [7:0]        f_sample,
    output logic              f_vldin,
    output logic [COEF_W-1:0] f_coeffs,
    output logic [3:0]        f_scale,
    input  logic [7:0]        f_result,
    input  logic              f_vldout,
    output logic [7:0]        m_result,
    output logic              m_vld
);
    localparam int c_tmr_w  = $clog2(FIR_LAT + 1);
    localparam int c_disc_w = $clog2(TAPS + 1);

    localparam logic [c_tmr_w-1:0]  c_tmr_load = c_tmr_w'(FIR_LAT);
    localparam logic [c_tmr_w-1:0]  c_tmr_one  = c_tmr_w'(1);
    localparam logic [c_disc_w-1:0] c_fl_last  = c_disc_w'(TAPS - 1);
    localparam logic [c_disc_w-1:0] c_disc_one = c_disc_w'(1);

    localparam logic [2:0] c_st_run    = 3'd0;
    localparam logic [2:0] c_st_drain  = 3'd1;
    localparam logic [2:0] c_st_load   = 3'd2;
    localparam logic [2:0] c_st_flush  = 3'd3;
    localparam logic [2:0] c_st_fdrain = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic                r_pending;
    logic [c_tmr_w-1:0]  r_timer;
    logic [c_disc_w-1:0] r_fcnt;
    logic [c_disc_w-1:0] r_discard;
    logic                w_inject;
    logic                w_suppress;
    logic                w_load_timer;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_run:    if (upd_req || r_pending) w_next = c_st_drain;
            c_st_drain:  if (r_timer == c_tmr_one) w_next = c_st_load;
            c_st_load:   w_next = flush_en ? c_st_flush : c_st_run;
            c_st_flush:  if (r_fcnt == c_fl_last) w_next = c_st_fdrain;
            c_st_fdrain: if (r_timer == c_tmr_one) w_next = c_st_run;
            default:     w_next = c_st_run;
        endcase
    end

    // Samples pass straight through in RUN; only FLUSH drives the FIR on its own.
    always_comb begin
        s_ready  = 1'b0;
        f_vldin  = 1'b0;
        f_sample = s_sample;
        case (r_state)
            c_st_run: begin
                s_ready = enable;
                f_vldin = s_valid & enable;
            end
            c_st_flush: begin
                f_vldin  = 1'b1;
                f_sample = 8'h00;
            end
            default: ;
        endcase
    end

    assign w_inject     = (r_state == c_st_flush);
    assign w_suppress   = f_vldout && (r_discard != '0);
    assign w_load_timer = ((r_state == c_st_run)   && (w_next == c_st_drain)) ||
                          ((r_state == c_st_flush) && (w_next == c_st_fdrain));

    assign m_result = f_result;
    assign m_vld    = f_vldout && (r_discard == '0);
    assign upd_busy = r_pending || (r_state != c_st_run);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_timer   <= '0;
            r_fcnt    <= '0;
            r_discard <= '0;
            f_coeffs  <= '0;
            f_scale   <= '0;
            upd_count <= '0;
        end else begin
            if (r_state == c_st_load) begin
                f_coeffs  <= sw_coeffs;
                f_scale   <= sw_scale;
                upd_count <= upd_count + CNT_W'(1);
            end

            // A request landing in LOAD itself must survive for the next round.
            if (upd_req) begin
                r_pending <= 1'b1;
            end else if (r_state == c_st_load) begin
                r_pending <= 1'b0;
            end

            if (w_load_timer) begin
                r_timer <= c_tmr_load;
            end else if (r_timer != '0) begin
                r_timer <= r_timer - c_tmr_one;
            end

            if (r_state == c_st_load) begin
                r_fcnt <= '0;
            end else if (w_inject) begin
                r_fcnt <= r_fcnt + c_disc_one;
            end

            case ({w_inject, w_suppress})
                2'b10:   r_discard <= r_discard + c_disc_one;
                2'b01:   r_discard <= r_discard - c_disc_one;
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fir_coef_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fir_coef_ctrl
// Randomized stream through a behavioural FIR stand-in; commit sequences are
// checked against timing derived from FIR_LAT and TAPS.
// Rev 1.0
// ============================================================================
module tb_fir_coef_ctrl;
    localparam int FIR_LAT     = 3;
    localparam int TAPS        = 8;
    localparam int COEF_W      = 64;
    localparam int CNT_W       = 16;
    localparam int STALL_PLAIN = FIR_LAT + 1;
    localparam int STALL_FLUSH = FIR_LAT + 1 + TAPS + FIR_LAT;
    localparam int LOAD_K      = FIR_LAT + 1;
    localparam int WIN         = STALL_FLUSH + 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [COEF_W-1:0] sw_coeffs;
    logic [3:0]        sw_scale;
    logic              flush_en;
    logic              upd_req;
    logic              upd_busy;
    logic [CNT_W-1:0]  upd_count;
    logic [7:0]        s_sample;
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        f_sample;
    logic              f_vldin;
    logic [COEF_W-1:0] f_coeffs;
    logic [3:0]        f_scale;
    logic [7:0]        f_result;
    logic              f_vldout;
    logic [7:0]        m_result;
    logic              m_vld;

    fir_coef_ctrl #(
        .FIR_LAT(FIR_LAT), .TAPS(TAPS), .COEF_W(COEF_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .sw_coeffs(sw_coeffs),
        .sw_scale(sw_scale), .flush_en(flush_en), .upd_req(upd_req),
        .upd_busy(upd_busy), .upd_count(upd_count), .s_sample(s_sample),
        .s_valid(s_valid), .s_ready(s_ready), .f_sample(f_sample),
        .f_vldin(f_vldin), .f_coeffs(f_coeffs), .f_scale(f_scale),
        .f_result(f_result), .f_vldout(f_vldout), .m_result(m_result),
        .m_vld(m_vld)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit         src_on;
    int         src_pct;
    int         xfer_cnt, m_cnt, sb_bad;
    logic [7:0] sb_got, sb_exp;
    logic [7:0] exp_q[$];
    logic [8:0] fir_q[$];

    logic              obs_ready, obs_vldin, obs_svalid, obs_busy, obs_mvld;
    logic [7:0]        obs_sample;
    logic [COEF_W-1:0] obs_coeffs;
    logic [3:0]        obs_scale;
    logic [CNT_W-1:0]  obs_count;

    logic [COEF_W-1:0] exp_coef;
    logic [3:0]        exp_scale;
    logic [CNT_W-1:0]  exp_count;

    int                mc_nready, mc_busy, mc_inject, mc_flush_bad, mc_vldin_any;
    logic              mc_busy_k0, mc_busy_k1, mc_ready_k0;
    logic [COEF_W-1:0] mc_coef_pre, mc_coef_post;
    logic [3:0]        mc_scale_post;

    // The FIR stand-in: result = sample ^ A5, FIR_LAT cycles after vldin.
    task automatic fir_clear();
        fir_q.delete();
        for (int i = 0; i < FIR_LAT - 1; i++) fir_q.push_back(9'h000);
    endtask

    task automatic sb_reset();
        sb_bad = 0; m_cnt = 0; xfer_cnt = 0; sb_got = '0; sb_exp = '0;
    endtask

    task automatic step();
        logic       xfer;
        logic [8:0] nxt;
        logic [7:0] e;
        #1;
        obs_ready  = s_ready;  obs_vldin = f_vldin;  obs_svalid = s_valid;
        obs_busy   = upd_busy; obs_mvld  = m_vld;    obs_sample = f_sample;
        obs_coeffs = f_coeffs; obs_scale = f_scale;  obs_count  = upd_count;
        xfer = s_valid & s_ready;
        if (m_vld === 1'b1) begin
            m_cnt++;
            if (exp_q.size() == 0) begin
                sb_bad++; sb_got = m_result; sb_exp = 8'hxx;
            end else begin
                e = exp_q.pop_front();
                if (m_result !== (e ^ 8'hA5)) begin
                    sb_bad++; sb_got = m_result; sb_exp = e ^ 8'hA5;
                end
            end
        end
        if (rst) begin
            exp_q.delete();
            fir_clear();
            nxt = 9'h000;
        end else begin
            if (xfer === 1'b1) begin
                exp_q.push_back(s_sample);
                xfer_cnt++;
            end
            fir_q.push_back({f_vldin, f_sample ^ 8'hA5});
            nxt = fir_q.pop_front();
        end
        @(posedge clk);
        #1;
        f_vldout = nxt[8];
        f_result = nxt[7:0];
        if (xfer === 1'b1 || !s_valid) begin
            s_valid  = src_on && ($urandom_range(99) < src_pct);
            s_sample = 8'($urandom);
        end
    endtask

    task automatic drain();
        int n = 0;
        src_on  = 1'b0;
        upd_req = 1'b0;
        while (s_valid && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (s_valid) begin
            errors++;
            $display("FAIL drain_timeout s_valid still %0b after %0d cycles", s_valid, n);
        end
        repeat (FIR_LAT + 4) step();
    endtask

    task automatic run_commit(input logic [COEF_W-1:0] coef, input logic [3:0] scale,
                              input logic flush);
        mc_nready = 0; mc_busy = 0; mc_inject = 0; mc_flush_bad = 0; mc_vldin_any = 0;
        for (int k = 0; k < WIN; k++) begin
            upd_req = (k == 0);
            if (k == LOAD_K) begin
                sw_coeffs = coef; sw_scale = scale; flush_en = flush;
            end else begin
                sw_coeffs = {$urandom, $urandom}; sw_scale = 4'($urandom); flush_en = 1'($urandom);
            end
            step();
            if (k == 0) begin mc_busy_k0 = obs_busy; mc_ready_k0 = obs_ready; end
            if (k == 1) mc_busy_k1 = obs_busy;
            if (k == LOAD_K) mc_coef_pre = obs_coeffs;
            if (k == LOAD_K + 1) begin mc_coef_post = obs_coeffs; mc_scale_post = obs_scale; end
            if (!obs_ready) mc_nready++;
            if (obs_busy) mc_busy++;
            if (obs_vldin) mc_vldin_any++;
            if (obs_vldin && !obs_ready) begin
                mc_inject++;
                if (obs_sample !== 8'h00) mc_flush_bad++;
            end
        end
        upd_req = 1'b0;
        flush_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; src_on = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        exp_coef = '0; exp_scale = '0; exp_count = '0;
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", obs_ready); end
        checks++; if (obs_coeffs !== '0) begin errors++; $display("FAIL reset_coeffs got=%h exp=0", obs_coeffs); end
        checks++; if (obs_scale !== 4'h0) begin errors++; $display("FAIL reset_scale got=%h exp=0", obs_scale); end
        checks++; if (obs_count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", obs_count); end
        checks++; if (obs_busy !== 1'b0 || obs_mvld !== 1'b0) begin
            errors++; $display("FAIL reset_busy_mvld got=%0b/%0b exp=0/0", obs_busy, obs_mvld);
        end
    endtask

    task automatic test_stream();
        int n = 0, vmm = 0, cnz = 0;
        sb_reset();
        src_on = 1'b1; src_pct = 100;
        while (xfer_cnt < 20 && n < 100) begin
            step();
            n++;
            if (obs_vldin !== (obs_svalid & enable)) vmm++;
            if (obs_coeffs !== '0) cnz++;
        end
        drain();
        checks++; if (vmm !== 0) begin errors++; $display("FAIL stream_vldin_mirror mismatches=%0d exp=0", vmm); end
        checks++; if (cnz !== 0) begin errors++; $display("FAIL stream_coeffs nonzero_cycles=%0d exp=0", cnz); end
        checks++; if (obs_count !== '0) begin errors++; $display("FAIL stream_count got=%0d exp=0", obs_count); end
        checks++; if (sb_bad !== 0 || exp_q.size() !== 0 || m_cnt !== xfer_cnt || xfer_cnt < 20) begin
            errors++; $display("FAIL stream_scoreboard bad=%0d left=%0d out=%0d in=%0d got=%h exp=%h",
                               sb_bad, exp_q.size(), m_cnt, xfer_cnt, sb_got, sb_exp);
        end
    endtask

    task automatic test_commit(input logic flush, input logic [COEF_W-1:0] coef,
                               input logic [3:0] scale);
        int exp_stall;
        exp_stall = flush ? STALL_FLUSH : STALL_PLAIN;
        sb_reset();
        src_on = 1'b1; src_pct = 100; enable = 1'b1;
        repeat (10) step();
        run_commit(coef, scale, flush);
        drain();
        exp_count = exp_count + 1'b1;
        checks++; if (mc_ready_k0 !== 1'b1 || mc_busy_k0 !== 1'b0 || mc_busy_k1 !== 1'b1) begin
            errors++; $display("FAIL commit%0b_req_cycle ready0=%0b busy0=%0b busy1=%0b exp=1/0/1",
                               flush, mc_ready_k0, mc_busy_k0, mc_busy_k1);
        end
        checks++; if (mc_nready !== exp_stall) begin errors++; $display("FAIL commit%0b_stall got=%0d exp=%0d", flush, mc_nready, exp_stall); end
        checks++; if (mc_busy !== exp_stall) begin errors++; $display("FAIL commit%0b_busy_len got=%0d exp=%0d", flush, mc_busy, exp_stall); end
        checks++; if (mc_inject !== (flush ? TAPS : 0) || mc_flush_bad !== 0) begin
            errors++; $display("FAIL commit%0b_flush inject=%0d exp=%0d nonzero=%0d", flush, mc_inject, flush ? TAPS : 0, mc_flush_bad);
        end
        checks++; if (mc_coef_pre !== exp_coef) begin errors++; $display("FAIL commit%0b_coef_pre got=%h exp=%h", flush, mc_coef_pre, exp_coef); end
        checks++; if (mc_coef_post !== coef || mc_scale_post !== scale) begin
            errors++; $display("FAIL commit%0b_coef_post got=%h/%h exp=%h/%h", flush, mc_coef_post, mc_scale_post, coef, scale);
        end
        checks++; if (obs_count !== exp_count) begin errors++; $display("FAIL commit%0b_count got=%0d exp=%0d", flush, obs_count, exp_count); end
        checks++; if (sb_bad !== 0 || exp_q.size() !== 0 || m_cnt !== xfer_cnt) begin
            errors++; $display("FAIL commit%0b_scoreboard bad=%0d left=%0d out=%0d in=%0d got=%h exp=%h",
                               flush, sb_bad, exp_q.size(), m_cnt, xfer_cnt, sb_got, sb_exp);
        end
        exp_coef = coef; exp_scale = scale;
    endtask

    task automatic test_multi_req();
        logic [COEF_W-1:0] c;
        int first = -1, last = -1, gaps = 0;
        logic end_busy;
        c = {$urandom, $urandom};
        sb_reset();
        src_on = 1'b1; src_pct = 100; enable = 1'b1;
        sw_coeffs = c; sw_scale = 4'h9; flush_en = 1'b1;
        repeat (4) step();
        for (int k = 0; k < 2 * WIN; k++) begin
            upd_req = (k == 0) || (k == 2) || (k == LOAD_K + 3);
            step();
            if (obs_busy) begin
                if (first < 0) first = k;
                else if (last >= 0 && last != k - 1) gaps++;
                last = k;
            end
        end
        upd_req = 1'b0;
        end_busy = obs_busy;
        flush_en = 1'b0;
        drain();
        exp_count = exp_count + 2'd2;
        checks++; if (gaps !== 0 || first !== 1) begin errors++; $display("FAIL multi_busy_gaps gaps=%0d first=%0d exp=0/1", gaps, first); end
        checks++; if (end_busy !== 1'b0) begin errors++; $display("FAIL multi_busy_end got=%0b exp=0", end_busy); end
        checks++; if (obs_count !== exp_count) begin errors++; $display("FAIL multi_count got=%0d exp=%0d", obs_count, exp_count); end
        checks++; if (obs_coeffs !== c || obs_scale !== 4'h9) begin
            errors++; $display("FAIL multi_coeffs got=%h/%h exp=%h/9", obs_coeffs, obs_scale, c);
        end
        checks++; if (sb_bad !== 0 || exp_q.size() !== 0 || m_cnt !== xfer_cnt) begin
            errors++; $display("FAIL multi_scoreboard bad=%0d left=%0d out=%0d in=%0d", sb_bad, exp_q.size(), m_cnt, xfer_cnt);
        end
        exp_coef = c; exp_scale = 4'h9;
    endtask

    task automatic test_reset_mid_flush();
        int n = 0;
        src_on = 1'b1; src_pct = 100; enable = 1'b1;
        sw_coeffs = {$urandom, $urandom}; sw_scale = 4'h5; flush_en = 1'b1;
        for (int k = 0; k <= LOAD_K + 4; k++) begin
            upd_req = (k == 0);
            rst     = (k == LOAD_K + 4);
            step();
        end
        upd_req = 1'b0; rst = 1'b0; flush_en = 1'b0;
        exp_coef = '0; exp_scale = '0; exp_count = '0;
        sb_reset();
        step();
        checks++; if (obs_ready !== 1'b1 || obs_busy !== 1'b0) begin
            errors++; $display("FAIL rstflush_ready_busy got=%0b/%0b exp=1/0", obs_ready, obs_busy);
        end
        checks++; if (obs_coeffs !== '0 || obs_count !== '0) begin
            errors++; $display("FAIL rstflush_regs coef=%h count=%0d exp=0/0", obs_coeffs, obs_count);
        end
        while (xfer_cnt < 15 && n < 100) begin step(); n++; end
        drain();
        checks++; if (sb_bad !== 0 || exp_q.size() !== 0 || m_cnt !== xfer_cnt || m_cnt < 15) begin
            errors++; $display("FAIL rstflush_scoreboard bad=%0d left=%0d out=%0d in=%0d", sb_bad, exp_q.size(), m_cnt, xfer_cnt);
        end
    endtask

    task automatic test_enable_low();
        logic [COEF_W-1:0] c;
        c = {$urandom, $urandom};
        sb_reset();
        src_on = 1'b1; src_pct = 100; enable = 1'b0;
        repeat (3) step();
        run_commit(c, 4'hC, 1'b0);
        exp_count = exp_count + 1'b1;
        checks++; if (mc_vldin_any !== 0 || mc_nready !== WIN) begin
            errors++; $display("FAIL enlow_idle vldin_cycles=%0d notready=%0d exp=0/%0d", mc_vldin_any, mc_nready, WIN);
        end
        checks++; if (mc_busy !== STALL_PLAIN) begin errors++; $display("FAIL enlow_busy_len got=%0d exp=%0d", mc_busy, STALL_PLAIN); end
        checks++; if (mc_coef_post !== c || obs_count !== exp_count) begin
            errors++; $display("FAIL enlow_commit coef=%h count=%0d exp=%h/%0d", mc_coef_post, obs_count, c, exp_count);
        end
        enable = 1'b1;
        drain();
        checks++; if (sb_bad !== 0 || exp_q.size() !== 0 || m_cnt !== xfer_cnt) begin
            errors++; $display("FAIL enlow_scoreboard bad=%0d left=%0d out=%0d in=%0d", sb_bad, exp_q.size(), m_cnt, xfer_cnt);
        end
        exp_coef = c; exp_scale = 4'hC;
    endtask

    task automatic test_back_to_back();
        logic [COEF_W-1:0] c;
        logic [3:0]        s;
        logic              fl;
        sb_reset();
        src_on = 1'b1; src_pct = 60; enable = 1'b1;
        for (int it = 0; it < 4; it++) begin
            repeat ($urandom_range(12, 2)) step();
            c = {$urandom, $urandom}; s = 4'($urandom); fl = 1'($urandom);
            run_commit(c, s, fl);
            exp_count = exp_count + 1'b1;
            checks++; if (mc_nready !== (fl ? STALL_FLUSH : STALL_PLAIN)) begin
                errors++; $display("FAIL b2b%0d_stall got=%0d exp=%0d", it, mc_nready, fl ? STALL_FLUSH : STALL_PLAIN);
            end
            checks++; if (mc_coef_post !== c || mc_scale_post !== s || obs_count !== exp_count) begin
                errors++; $display("FAIL b2b%0d_commit coef=%h scale=%h count=%0d exp=%h/%h/%0d",
                                   it, mc_coef_post, mc_scale_post, obs_count, c, s, exp_count);
            end
        end
        drain();
        checks++; if (sb_bad !== 0 || exp_q.size() !== 0 || m_cnt !== xfer_cnt) begin
            errors++; $display("FAIL b2b_scoreboard bad=%0d left=%0d out=%0d in=%0d got=%h exp=%h",
                               sb_bad, exp_q.size(), m_cnt, xfer_cnt, sb_got, sb_exp);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; sw_coeffs = '0; sw_scale = '0; flush_en = 1'b0;
        upd_req = 1'b0; s_sample = '0; s_valid = 1'b0; f_result = '0; f_vldout = 1'b0;
        src_on = 1'b0; src_pct = 100;
        fir_clear();
        sb_reset();
        test_reset();
        test_stream();
        test_commit(1'b0, 64'h0102030405060708, 4'd3);
        test_commit(1'b1, 64'h1122334455667788, 4'd7);
        test_multi_req();
        test_reset_mid_flush();
        test_enable_low();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
